// File: rtl/mdf_pkg.sv
// Shared encodings and default sizes for the iterative multiply/divide unit.
// State encodings are visible on stateOut, so their values are fixed here.
package mdf_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_TAG_W = 4;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_MULH = 2'b01,
    OP_DIV  = 2'b10,
    OP_REM  = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_CALC = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  function automatic logic is_div_op(input op_t op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/mdf_seq_core.sv
// One-bit-per-cycle datapath: shift-add multiply or restoring divide on unsigned magnitudes.
// After WIDTH steps {hi,lo} holds the product, or hi = remainder and lo = quotient.
module mdf_seq_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic             load,
  input  logic             step,
  input  logic             div_mode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             last
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] addend;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             fits;

  assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, addend} : {(WIDTH+1){1'b0}});
  // The partial remainder is always below the divisor, so the difference fits in WIDTH bits.
  assign shifted = {hi, lo[WIDTH-1]};
  assign fits    = (shifted >= {1'b0, addend});
  assign diff    = shifted[WIDTH-1:0] - addend;
  assign last    = (count == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      hi     <= '0;
      lo     <= '0;
      addend <= '0;
      count  <= '0;
    end else if (load) begin
      hi    <= '0;
      count <= '0;
      if (div_mode) begin
        lo     <= op_a;
        addend <= op_b;
      end else begin
        lo     <= op_b;
        addend <= op_a;
      end
    end else if (step) begin
      count <= count + 1'b1;
      if (div_mode) begin
        hi <= fits ? diff : shifted[WIDTH-1:0];
        lo <= {lo[WIDTH-2:0], fits};
      end else begin
        hi <= mul_sum[WIDTH:1];
        lo <= {mul_sum[0], lo[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/mdf_iter_alu.sv
// Iterative MUL/MULH/DIV/REM unit for a reservation-station / common-data-bus pipeline.
// Holds the control FSM, issue/accept handshake, sign handling and the registered result.
module mdf_iter_alu
  import mdf_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int TAG_W = DEF_TAG_W
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic             inEN,
  output logic             inReady,
  input  logic [1:0]       op,
  input  logic             isSigned,
  input  logic [WIDTH-1:0] dataIn1,
  input  logic [WIDTH-1:0] dataIn2,
  input  logic [TAG_W-1:0] tagIn,
  input  logic             flush,
  output logic [WIDTH-1:0] result,
  output logic [TAG_W-1:0] resultTag,
  output logic             resultValid,
  input  logic             resultAC,
  output logic             divZero,
  output logic [2:0]       stateOut
);

  state_t           state;
  op_t              op_q;
  logic             sgn_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             res_neg;

  logic             issue;
  logic             neg_a;
  logic             neg_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] core_hi;
  logic [WIDTH-1:0] core_lo;
  logic             core_last;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] fix_value;

  assign inReady  = (state == ST_IDLE) || ((state == ST_DONE) && resultAC);
  assign issue    = inEN && inReady;
  assign stateOut = state;

  assign neg_a = sgn_q && a_q[WIDTH-1];
  assign neg_b = sgn_q && b_q[WIDTH-1];
  assign mag_a = neg_a ? (~a_q + 1'b1) : a_q;
  assign mag_b = neg_b ? (~b_q + 1'b1) : b_q;

  mdf_seq_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .nRST     (nRST),
    .load     (state == ST_PREP),
    .step     (state == ST_CALC),
    .div_mode (is_div_op(op_q)),
    .op_a     (mag_a),
    .op_b     (mag_b),
    .hi       (core_hi),
    .lo       (core_lo),
    .last     (core_last)
  );

  // Sign correction on the unsigned core outputs; the remainder follows the dividend sign.
  always_comb begin
    prod_fix  = res_neg ? (~{core_hi, core_lo} + 1'b1) : {core_hi, core_lo};
    quo_fix   = res_neg ? (~core_lo + 1'b1) : core_lo;
    rem_fix   = res_neg ? (~core_hi + 1'b1) : core_hi;
    fix_value = '0;
    case (op_q)
      OP_MUL:  fix_value = prod_fix[WIDTH-1:0];
      OP_MULH: fix_value = prod_fix[2*WIDTH-1:WIDTH];
      OP_DIV:  fix_value = quo_fix;
      OP_REM:  fix_value = rem_fix;
      default: fix_value = '0;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state       <= ST_IDLE;
      op_q        <= OP_MUL;
      sgn_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      res_neg     <= 1'b0;
      result      <= '0;
      resultTag   <= '0;
      resultValid <= 1'b0;
      divZero     <= 1'b0;
    end else if (flush) begin
      state       <= ST_IDLE;
      resultValid <= 1'b0;
      divZero     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: state <= ST_IDLE;
        ST_PREP: begin
          res_neg <= (op_q == OP_REM) ? neg_a : (neg_a ^ neg_b);
          if (is_div_op(op_q) && (b_q == '0)) begin
            result      <= (op_q == OP_REM) ? a_q : '1;
            divZero     <= 1'b1;
            resultValid <= 1'b1;
            state       <= ST_DONE;
          end else begin
            state <= ST_CALC;
          end
        end
        ST_CALC: if (core_last) state <= ST_FIX;
        ST_FIX: begin
          result      <= fix_value;
          divZero     <= 1'b0;
          resultValid <= 1'b1;
          state       <= ST_DONE;
        end
        ST_DONE: begin
          if (resultAC) begin
            resultValid <= 1'b0;
            divZero     <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
      // A new issue overrides the IDLE return, giving back-to-back operation out of DONE.
      if (issue) begin
        op_q      <= op_t'(op);
        sgn_q     <= isSigned;
        a_q       <= dataIn1;
        b_q       <= dataIn2;
        resultTag <= tagIn;
        state     <= ST_PREP;
      end
    end
  end

endmodule

// File: tb/tb_mdf_iter_alu.sv
// Self-checking bench for mdf_iter_alu: directed corner cases plus a randomized stream
// compared every cycle against a transaction-level model with a queue of pending results.
module tb_mdf_iter_alu;

  localparam int W   = 32;
  localparam int TW  = 4;
  localparam int LAT = W + 3;

  typedef struct packed {
    logic [W-1:0] res;
    logic         dz;
  } exp_t;

  typedef struct {
    logic [W-1:0]  res;
    logic [TW-1:0] tag;
    logic          dz;
    int            due;
  } pend_t;

  logic          clk = 1'b0;
  logic          nRST;
  logic          inEN;
  logic          inReady;
  logic [1:0]    op;
  logic          isSigned;
  logic [W-1:0]  dataIn1;
  logic [W-1:0]  dataIn2;
  logic [TW-1:0] tagIn;
  logic          flush;
  logic [W-1:0]  result;
  logic [TW-1:0] resultTag;
  logic          resultValid;
  logic          resultAC = 1'b1;
  logic          divZero;
  logic [2:0]    stateOut;

  logic  ac_manual = 1'b1;
  logic  rand_ac = 1'b0;
  int    cyc = 0;
  int    n_cmp = 0;
  int    n_fail = 0;
  pend_t exp_q[$];

  mdf_iter_alu #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk         (clk),
    .nRST        (nRST),
    .inEN        (inEN),
    .inReady     (inReady),
    .op          (op),
    .isSigned    (isSigned),
    .dataIn1     (dataIn1),
    .dataIn2     (dataIn2),
    .tagIn       (tagIn),
    .flush       (flush),
    .result      (result),
    .resultTag   (resultTag),
    .resultValid (resultValid),
    .resultAC    (resultAC),
    .divZero     (divZero),
    .stateOut    (stateOut)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    resultAC = rand_ac ? ($urandom_range(0, 3) != 0) : ac_manual;
  end

  // Reference arithmetic straight from the operation definitions using 64-bit integers.
  function automatic exp_t model(input logic [1:0] o, input logic s,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t         e;
    int           ia, ib;
    longint       sa, sb, sp;
    logic [63:0]  p;
    e.dz = 1'b0;
    ia = a;
    ib = b;
    sa = ia;
    sb = ib;
    if (o[1] == 1'b0) begin
      if (s) begin
        sp = sa * sb;
        p  = sp;
      end else begin
        p = {32'b0, a} * {32'b0, b};
      end
      e.res = (o == 2'b00) ? p[31:0] : p[63:32];
    end else if (b == 0) begin
      e.res = (o == 2'b10) ? 32'hFFFFFFFF : a;
      e.dz  = 1'b1;
    end else if (s) begin
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) e.res = (o == 2'b10) ? a : 32'h0;
      else begin
        sp    = (o == 2'b10) ? (sa / sb) : (sa % sb);
        p     = sp;
        e.res = p[31:0];
      end
    end else begin
      e.res = (o == 2'b10) ? (a / b) : (a % b);
    end
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeoutFail(input string name);
    n_cmp++;
    n_fail++;
    $display("[TB] FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // Cycle-level compare against the pending-result queue.
  logic  mon_valid;
  logic  mon_ready;
  exp_t  mon_m;
  pend_t mon_p;

  always @(negedge clk) begin
    if (!nRST) begin
      exp_q.delete();
      checkOutput("rst_valid", resultValid, 0);
      checkOutput("rst_result", result, 0);
      checkOutput("rst_tag", resultTag, 0);
      checkOutput("rst_divzero", divZero, 0);
      checkOutput("rst_state", stateOut, 0);
    end else begin
      mon_valid = (exp_q.size() > 0) && (cyc >= exp_q[0].due);
      checkOutput("valid", resultValid, mon_valid);
      if (mon_valid) begin
        checkOutput("result", result, exp_q[0].res);
        checkOutput("tag", resultTag, exp_q[0].tag);
        checkOutput("divzero", divZero, exp_q[0].dz);
      end else begin
        checkOutput("divzero_idle", divZero, 0);
      end
      mon_ready = (exp_q.size() == 0) || (mon_valid && resultAC);
      checkOutput("ready", inReady, mon_ready);
      if (flush) exp_q.delete();
      else begin
        if (mon_valid && resultAC) void'(exp_q.pop_front());
        if (inEN && mon_ready) begin
          mon_m     = model(op, isSigned, dataIn1, dataIn2);
          mon_p.res = mon_m.res;
          mon_p.dz  = mon_m.dz;
          mon_p.tag = tagIn;
          mon_p.due = cyc + (mon_m.dz ? 2 : LAT);
          exp_q.push_back(mon_p);
        end
      end
    end
  end

  task automatic applyStimulus(input logic [1:0] o, input logic s, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic [TW-1:0] t, output int issue_cyc);
    op = o; isSigned = s; dataIn1 = a; dataIn2 = b; tagIn = t; inEN = 1'b1;
    issue_cyc = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (inReady && !flush) begin
        issue_cyc = cyc;
        break;
      end
    end
    if (issue_cyc < 0) timeoutFail("issue_accept");
    @(posedge clk);
    #1 inEN = 1'b0;
  endtask

  task automatic waitResult(input int issue_cyc, output int lat);
    lat = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (resultValid) begin
        lat = cyc - issue_cyc;
        break;
      end
    end
    if (lat < 0) timeoutFail("result_wait");
  endtask

  task automatic runOp(input string name, input logic [1:0] o, input logic s,
                       input logic [W-1:0] a, input logic [W-1:0] b, input logic [TW-1:0] t,
                       input logic [W-1:0] exp_res, input logic exp_dz, input int exp_lat);
    int ic, lat;
    applyStimulus(o, s, a, b, t, ic);
    waitResult(ic, lat);
    checkOutput({name, "_latency"}, lat, exp_lat);
    checkOutput({name, "_result"}, result, exp_res);
    checkOutput({name, "_divzero"}, divZero, exp_dz);
    checkOutput({name, "_tag"}, resultTag, t);
    @(negedge clk);
    checkOutput({name, "_valid_drop"}, resultValid, 0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] pickOperand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int ic, lat;
    logic seen;
    exp_t m;
    nRST = 1'b0; inEN = 1'b0; flush = 1'b0;
    op = 2'b00; isSigned = 1'b0; dataIn1 = '0; dataIn2 = '0; tagIn = '0;
    #1;
    checkOutput("reset_valid", resultValid, 0);
    checkOutput("reset_result", result, 0);
    checkOutput("reset_state", stateOut, 0);
    checkOutput("reset_ready", inReady, 1);
    @(posedge clk); @(posedge clk);
    #2 nRST = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] directed operations");
    runOp("mul_5x10", 2'b00, 1'b0, 32'd5, 32'd10, 4'd3, 32'd50, 1'b0, LAT);
    runOp("div_s_m7_2", 2'b10, 1'b1, 32'hFFFFFFF9, 32'd2, 4'd4, 32'hFFFFFFFD, 1'b0, LAT);
    runOp("rem_s_m7_2", 2'b11, 1'b1, 32'hFFFFFFF9, 32'd2, 4'd5, 32'hFFFFFFFF, 1'b0, LAT);
    runOp("mulh_s_m1", 2'b01, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd6, 32'h0, 1'b0, LAT);
    runOp("mulh_u_max", 2'b01, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd7, 32'hFFFFFFFE, 1'b0, LAT);
    runOp("div_by_zero", 2'b10, 1'b0, 32'd100, 32'd0, 4'd8, 32'hFFFFFFFF, 1'b1, 2);
    runOp("rem_by_zero", 2'b11, 1'b0, 32'd100, 32'd0, 4'd9, 32'd100, 1'b1, 2);
    runOp("div_ovf", 2'b10, 1'b1, 32'h80000000, 32'hFFFFFFFF, 4'd10, 32'h80000000, 1'b0, LAT);
    runOp("rem_ovf", 2'b11, 1'b1, 32'h80000000, 32'hFFFFFFFF, 4'd11, 32'h0, 1'b0, LAT);

    $display("[TB] result held in DONE, then back-to-back issue");
    ac_manual = 1'b0;
    applyStimulus(2'b00, 1'b0, 32'd7, 32'd6, 4'd9, ic);
    waitResult(ic, lat);
    checkOutput("hold_latency", lat, LAT);
    @(posedge clk);
    #1;
    op = 2'b10; isSigned = 1'b0; dataIn1 = 32'd55; dataIn2 = 32'd5; tagIn = 4'd2; inEN = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checkOutput("hold_result", result, 42);
      checkOutput("hold_tag", resultTag, 9);
      checkOutput("hold_state", stateOut, 4);
      @(posedge clk);
      #1;
    end
    ac_manual = 1'b1;
    op = 2'b01; dataIn1 = 32'h12345678; dataIn2 = 32'h9ABCDEF0; tagIn = 4'd5;
    @(negedge clk);
    checkOutput("b2b_ready", inReady, 1);
    ic = cyc;
    @(posedge clk);
    #1 inEN = 1'b0;
    @(negedge clk);
    checkOutput("b2b_state_prep", stateOut, 1);
    waitResult(ic, lat);
    m = model(2'b01, 1'b0, 32'h12345678, 32'h9ABCDEF0);
    checkOutput("b2b_latency", lat, LAT);
    checkOutput("b2b_result", result, m.res);
    @(posedge clk);
    #1;

    $display("[TB] flush during CALC");
    applyStimulus(2'b10, 1'b0, 32'd1000, 32'd3, 4'd1, ic);
    repeat (7) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    checkOutput("flush_in_calc", stateOut, 2);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    checkOutput("flush_state_idle", stateOut, 0);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (resultValid) seen = 1'b1;
    end
    checkOutput("flush_no_valid", seen, 0);
    @(posedge clk);
    #1;

    $display("[TB] reset during CALC");
    applyStimulus(2'b00, 1'b1, 32'hFFFFFFFD, 32'd7, 4'd6, ic);
    repeat (10) @(posedge clk);
    #2 nRST = 1'b0;
    #1;
    checkOutput("midrst_result", result, 0);
    checkOutput("midrst_valid", resultValid, 0);
    checkOutput("midrst_state", stateOut, 0);
    checkOutput("midrst_ready", inReady, 1);
    #4 nRST = 1'b1;
    @(posedge clk);
    #1;
    runOp("after_rst", 2'b00, 1'b1, 32'hFFFFFFFD, 32'd7, 4'd12, 32'hFFFFFFEB, 1'b0, LAT);

    $display("[TB] randomized stream");
    rand_ac = 1'b1;
    for (int i = 0; i < 120; i++) begin
      applyStimulus(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), pickOperand(),
                    pickOperand(), 4'($urandom_range(0, 15)), ic);
      if ($urandom_range(0, 9) == 0) begin
        repeat ($urandom_range(0, 40)) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
      end
    end
    rand_ac = 1'b0;
    ac_manual = 1'b1;
    for (int k = 0; k < 100 && exp_q.size() > 0; k++) @(negedge clk);
    if (exp_q.size() > 0) timeoutFail("drain");
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mdf_iter_alu.md
MDF_ITER_ALU -- requirements
Module: mdf_iter_alu

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width (>=4, even).
REQ-002 Parameter TAG_W, default 4, reservation-station tag width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 nRST  input  1  reset, asynchronous, active-low.
REQ-005 inEN  input  1  issue valid from reservation station.
REQ-006 inReady  output  1  unit can accept issue this cycle.
REQ-007 op  input  2  operation: 00 MUL (low half), 01 MULH (high half), 10 DIV (quotient), 11 REM.
REQ-008 isSigned  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-009 dataIn1 / dataIn2  input  WIDTH each  multiplicand or dividend / multiplier or divisor.
REQ-010 tagIn  input  TAG_W  tag of the issuing instruction.
REQ-011 flush  input  1  abort any operation in flight.
REQ-012 result  output  WIDTH  computed value.
REQ-013 resultTag  output  TAG_W  tag captured at issue.
REQ-014 resultValid  output  1  result/resultTag/divZero valid for the common data bus.
REQ-015 resultAC  input  1  common data bus accepted the result.
REQ-016 divZero  output  1  DIV/REM had a zero divisor.
REQ-017 stateOut  output  3  current FSM state encoding.

Function
REQ-018 FSM states: IDLE, PREP, CALC, FIX, DONE.
REQ-019 inReady SHALL be high in IDLE, and in DONE while resultAC is high; low otherwise.
REQ-020 Issue SHALL occur when inEN and inReady are high at a rising edge; op, isSigned, operands and tag are captured; next state PREP.
REQ-021 An inEN with inReady low SHALL be ignored, with no state change.
REQ-022 PREP: the unit takes operand magnitudes when isSigned, records the result sign, and clears the CALC counter; next state CALC, or DONE when op is DIV/REM and the divisor is zero.
REQ-023 CALC: one bit per cycle (shift-add multiply, restoring divide) for exactly WIDTH cycles; next state FIX.
REQ-024 FIX: the unit applies the sign correction (quotient sign = sign1 XOR sign2; remainder sign = dividend sign) and selects the output half; next state DONE.
REQ-025 Latency: resultValid SHALL rise exactly WIDTH+3 edges after the issue edge (1 PREP, WIDTH CALC, 1 FIX, registered into DONE).
REQ-026 DONE: resultValid=1; result, resultTag and divZero held stable until resultAC is sampled high; then IDLE, or PREP if a new issue coincides.
REQ-027 Divide by zero: result = all ones for DIV and dividendIn for REM; divZero=1; reached 2 edges after issue.
REQ-028 Signed overflow (min value / -1): DIV returns the min value, REM returns 0, divZero=0.
REQ-029 MULH returns the upper WIDTH bits of the 2*WIDTH signed or unsigned product.
REQ-030 flush SHALL force IDLE at the next edge from any state and drop resultValid; flush wins over a simultaneous issue or resultAC.
REQ-031 divZero SHALL be 0 whenever resultValid is 0.

Reset
REQ-032 On nRST low, immediately: state IDLE, resultValid 0, result 0, resultTag 0, divZero 0, stateOut = IDLE encoding, internal counters/registers 0.
REQ-033 Reset mid-operation SHALL discard the operation with no result emitted; inReady is 1 once nRST is released.

Structure
REQ-034 Shared package mdf_pkg SHALL hold the op encodings, the 3-bit state encodings (IDLE=0, PREP=1, CALC=2, FIX=3, DONE=4) and the default WIDTH/TAG_W constants.
REQ-035 Iteration datapath SHALL be one sub-module mdf_seq_core (accumulator/remainder, shift register, bit counter); mdf_iter_alu holds the FSM, handshake, sign handling and output registers.

Verification (WIDTH=32)
REQ-036 MUL unsigned 5 x 10, resultAC=1 -> result=50, tag echoed, resultValid exactly 35 edges after issue, for one cycle.
REQ-037 DIV signed -7 / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; MULH signed 0xFFFFFFFF x 0xFFFFFFFF -> 0; MULH unsigned same operands -> 0xFFFFFFFE.
REQ-038 DIV 100 / 0 -> 0xFFFFFFFF, divZero=1 two edges after issue; REM 100 / 0 -> 100; DIV signed 0x80000000 / -1 -> 0x80000000, REM -> 0.
REQ-039 resultAC held low 10 cycles in DONE -> outputs stable and inEN ignored; resultAC and inEN high together -> next op enters PREP with no idle cycle.
REQ-040 flush in CALC cycle 7 -> IDLE next edge, no resultValid; nRST pulsed mid-CALC -> outputs 0 immediately, next issue completes correctly.
